// File: rtl/z8_fetch_unit.sv
// Z8 instruction prefetch unit: byte FIFO fed from synchronous program memory,
// presents whole 1/2/3-byte instructions. Optional same-cycle bypass: FETCH_BYPASS_EN.
module z8_fetch_unit #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memStrobe,
   input  logic [7:0]            memDataRead,
   output logic                  instrValid,
   input  logic                  instrReady,
   output logic [7:0]            instruction,
   output logic [7:0]            second,
   output logic [7:0]            third,
   output logic [1:0]            instrSize,
   output logic [ADDR_WIDTH-1:0] instrPc,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirectAddr
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned AW = CW + 1;
   localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

   logic [7:0]            fifo_q [DEPTH];
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  pending_q, pending_d;
   logic                  drop_q, drop_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;

   logic                  resp_valid_c;
   logic                  strobe_c;
   logic                  fire_c;
   logic                  wr_en_c;
   logic [2:0][7:0]       byte_c;
   logic [1:0]            size_c;
   logic [AW-1:0]         avail_c;

   function automatic logic [1:0] decode_size(input logic [3:0] lo);
      case (lo)
         4'hE, 4'hF:                   decode_size = 2'd1;
         4'h4, 4'h5, 4'h6, 4'h7, 4'hD: decode_size = 2'd3;
         default:                      decode_size = 2'd2;
      endcase
   endfunction

   assign resp_valid_c = pending_q & ~drop_q;

   // Head window: up to three bytes in fetch order, wrapping around the FIFO.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         byte_c[k] = fifo_q[rd_ptr_q + PW'(k)];
`ifdef FETCH_BYPASS_EN
         if (resp_valid_c && (count_q == CW'(k))) begin
            byte_c[k] = memDataRead;
         end
`endif
      end
   end

   assign size_c = decode_size(byte_c[0][3:0]);

`ifdef FETCH_BYPASS_EN
   assign avail_c = AW'(count_q) + AW'(resp_valid_c);
`else
   assign avail_c = AW'(count_q);
`endif

   // Pops in the same cycle are deliberately not credited to the strobe decision.
   assign strobe_c = ~reset & ~redirect
                   & ((AW'(count_q) + AW'(pending_q)) < AW'(DEPTH));
   assign fire_c   = instrValid & instrReady & ~redirect;

   assign memStrobe   = strobe_c;
   assign memAddr     = fetch_pc_q;
   assign instrPc     = head_pc_q;
   assign instrSize   = size_c;
   assign instrValid  = (avail_c >= AW'(size_c));
   assign instruction = byte_c[0];
   assign second      = (size_c >= 2'd2) ? byte_c[1] : 8'h00;
   assign third       = (size_c == 2'd3) ? byte_c[2] : 8'h00;

   // Next-state; redirect overrides push, pop and strobe.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      head_pc_d  = head_pc_q;
      pending_d  = strobe_c;
      drop_d     = 1'b0;
      wr_en_c    = 1'b0;
      if (redirect) begin
         count_d    = '0;
         wr_ptr_d   = rd_ptr_q;
         fetch_pc_d = redirectAddr;
         head_pc_d  = redirectAddr;
         drop_d     = pending_q;
      end else begin
         if (strobe_c) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
         end
         if (resp_valid_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            // A byte consumed straight off the bus never needs a FIFO slot.
            wr_en_c  = ~(fire_c && (count_q < CW'(size_c)));
         end
         if (fire_c) begin
            rd_ptr_d  = rd_ptr_q + PW'(size_c);
            head_pc_d = head_pc_q + ADDR_WIDTH'(size_c);
         end
         count_d = count_q + CW'(resp_valid_c) - (fire_c ? CW'(size_c) : CW'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         pending_q  <= 1'b0;
         drop_q     <= 1'b0;
         fetch_pc_q <= RST_PC;
         head_pc_q  <= RST_PC;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[PW'(i)] <= 8'h00;
         end
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
         fetch_pc_q <= fetch_pc_d;
         head_pc_q  <= head_pc_d;
         if (wr_en_c) begin
            fifo_q[wr_ptr_q] <= memDataRead;
         end
      end
   end

endmodule

// File: tb/tb_z8_fetch_unit.sv
// Bench for z8_fetch_unit: memory image model, instruction-stream model walked
// from the image, per-cycle compare process plus directed literal checks.
module tb_z8_fetch_unit;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, memStrobe, instrValid, instrReady, redirect;
   logic [7:0] memAddr, memDataRead, instruction, second, third, instrPc, redirectAddr;
   logic [1:0] instrSize;

   z8_fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(0)) dut (
      .clk(clk), .reset(reset), .memAddr(memAddr), .memStrobe(memStrobe),
      .memDataRead(memDataRead), .instrValid(instrValid), .instrReady(instrReady),
      .instruction(instruction), .second(second), .third(third),
      .instrSize(instrSize), .instrPc(instrPc), .redirect(redirect),
      .redirectAddr(redirectAddr)
   );

`ifdef FETCH_BYPASS_EN
   localparam int LAT1 = 1;
`else
   localparam int LAT1 = 2;
`endif

   typedef struct {
      logic [7:0] pc;
      logic [1:0] sz;
      logic [7:0] b0, b1, b2;
   } ins_t;

   logic [7:0]  img [256];
   ins_t        exp_q[$];
   ins_t        acc_log[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          strobe_cnt = 0;
   logic [7:0]  exp_fetch;
   logic        hold_v;
   logic [33:0] held;
   int          first_v, k;
   logic        found;
   ins_t        rec;

   // Program memory: one-cycle read latency.
   always @(posedge clk) if (memStrobe) memDataRead <= img[memAddr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [1:0] spec_size(input logic [7:0] op);
      logic [3:0] lo;
      lo = op[3:0];
      if (lo >= 4'd14) return 2'd1;
      if ((lo >= 4'd4 && lo <= 4'd7) || lo == 4'd13) return 2'd3;
      return 2'd2;
   endfunction

   // Walk the image from a start address, producing the expected instruction stream.
   function automatic void build(input logic [7:0] start);
      logic [7:0] p;
      ins_t e;
      p = start;
      exp_q.delete();
      for (int n = 0; n < 64; n++) begin
         e.pc = p;
         e.b0 = img[p];
         e.sz = spec_size(e.b0);
         e.b1 = (e.sz >= 2'd2) ? img[8'(p + 8'd1)] : 8'h00;
         e.b2 = (e.sz == 2'd3) ? img[8'(p + 8'd2)] : 8'h00;
         exp_q.push_back(e);
         p = 8'(p + 8'(e.sz));
      end
   endfunction

   function automatic void load_filler();
      for (int a = 0; a < 256; a++) img[a] = 8'(a * 29 + 3);
   endfunction

   function automatic void load_stream();
      load_filler();
      img[0] = 8'hFF; img[1] = 8'h8F; img[2] = 8'hB0; img[3] = 8'h12;
      img[4] = 8'hE6; img[5] = 8'h20; img[6] = 8'h55;
   endfunction

   // Compare process: fetch addresses, accepted instructions, hold stability.
   always @(negedge clk) begin
      if (reset) begin
         build(8'h00);
         exp_fetch = 8'h00;
         hold_v    = 1'b0;
      end else begin
         if (hold_v)
            chk("hold", {instrValid, instrPc, instrSize, instruction, second, third}, {1'b1, held});
         if (memStrobe) begin
            chk("fetch_addr", memAddr, exp_fetch);
            exp_fetch = exp_fetch + 8'd1;
            strobe_cnt++;
         end
         if (redirect) begin
            chk("strobe_during_redirect", memStrobe, 1'b0);
            build(redirectAddr);
            exp_fetch = redirectAddr;
         end else if (instrValid && instrReady) begin
            rec.pc = instrPc; rec.sz = instrSize;
            rec.b0 = instruction; rec.b1 = second; rec.b2 = third;
            acc_log.push_back(rec);
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL model_underrun: got pc %0h expected no instruction", instrPc);
            end else begin
               chk("instr", {instrPc, instrSize, instruction, second, third},
                   {exp_q[0].pc, exp_q[0].sz, exp_q[0].b0, exp_q[0].b1, exp_q[0].b2});
               void'(exp_q.pop_front());
            end
         end
         hold_v = instrValid && !instrReady && !redirect;
         held   = {instrPc, instrSize, instruction, second, third};
      end
   end

   task automatic wait_acc(input int n, input int budget);
      int c;
      c = 0;
      while (acc_log.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("acc_wait", 64'(acc_log.size() >= n), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; redirect = 1'b0; redirectAddr = 8'h00; instrReady = 1'b1;
      load_stream();

      // Reset values and model pins
      repeat (3) @(negedge clk);
      chk("rst_strobe", memStrobe, 1'b0);
      chk("rst_valid", instrValid, 1'b0);
      chk("rst_bytes", {instruction, second, third}, 24'h0);
      chk("rst_size", instrSize, 2'd2);
      chk("rst_addr", memAddr, 8'h00);
      chk("rst_pc", instrPc, 8'h00);
      chk("model_pin0", {exp_q[0].pc, exp_q[0].sz, exp_q[0].b0}, {8'h00, 2'd1, 8'hFF});
      chk("model_pin3", {exp_q[3].pc, exp_q[3].sz, exp_q[3].b0, exp_q[3].b1, exp_q[3].b2},
          {8'h04, 2'd3, 8'hE6, 8'h20, 8'h55});

      // Streaming with ready high
      acc_log.delete();
      @(posedge clk); #1 reset = 1'b0;
      first_v = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) chk("c0_strobe_addr", {memStrobe, memAddr}, {1'b1, 8'h00});
         if (instrValid && first_v < 0) first_v = c;
      end
      chk("first_valid_cycle", 64'(first_v), 64'(LAT1));
      wait_acc(4, 40);
      chk("stream0", {acc_log[0].pc, acc_log[0].sz, acc_log[0].b0}, {8'h00, 2'd1, 8'hFF});
      chk("stream1", {acc_log[1].pc, acc_log[1].sz, acc_log[1].b0}, {8'h01, 2'd1, 8'h8F});
      chk("stream2", {acc_log[2].pc, acc_log[2].sz, acc_log[2].b0, acc_log[2].b1, acc_log[2].b2},
          {8'h02, 2'd2, 8'hB0, 8'h12, 8'h00});
      chk("stream3", {acc_log[3].pc, acc_log[3].sz, acc_log[3].b0, acc_log[3].b1, acc_log[3].b2},
          {8'h04, 2'd3, 8'hE6, 8'h20, 8'h55});

      // Backpressure from reset: FIFO fills, strobes stop
      reset = 1'b1; instrReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; strobe_cnt = 0; acc_log.delete();
      repeat (12) @(negedge clk);
      chk("bp_strobes", 64'(strobe_cnt), 64'd4);
      chk("bp_head", {instrValid, instrPc, instruction, instrSize}, {1'b1, 8'h00, 8'hFF, 2'd1});
      chk("bp_none_taken", 64'(acc_log.size()), 64'd0);
      @(posedge clk); #1 instrReady = 1'b1;
      wait_acc(4, 40);
      chk("bp_resume_pcs", {acc_log[0].pc, acc_log[1].pc, acc_log[2].pc, acc_log[3].pc}, 32'h00010204);

      // Redirect right after a strobe to 0x07
      reset = 1'b1; load_filler();
      img[8'h40] = 8'h0E; img[8'h80] = 8'hB9; img[8'h81] = 8'h3C;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      found = 1'b0; k = 0;
      while (!found && k < 30) begin
         @(negedge clk);
         found = memStrobe && (memAddr == 8'h07);
         k++;
      end
      chk("saw_strobe_07", found, 1'b1);
      @(posedge clk); #1 redirect = 1'b1; redirectAddr = 8'h40; acc_log.delete();
      @(negedge clk);
      chk("redir_no_strobe", memStrobe, 1'b0);
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("redir_next_strobe", {memStrobe, memAddr}, {1'b1, 8'h40});
      first_v = instrValid ? 0 : -1;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         if (instrValid && first_v < 0) first_v = c;
      end
      chk("redir_latency", 64'(first_v), 64'(LAT1));
      wait_acc(1, 20);
      chk("redir_first", {acc_log[0].pc, acc_log[0].sz, acc_log[0].b0}, {8'h40, 2'd1, 8'h0E});

      // Redirect coincident with a handshake
      @(posedge clk); #1 instrReady = 1'b0;
      found = 1'b0; k = 0;
      while (!found && k < 20) begin
         @(negedge clk);
         found = instrValid;
         k++;
      end
      chk("coinc_valid_wait", found, 1'b1);
      @(posedge clk); #1 instrReady = 1'b1; redirect = 1'b1; redirectAddr = 8'h80; acc_log.delete();
      @(negedge clk);
      chk("coinc_handshake", {instrValid, instrReady, redirect}, 3'b111);
      @(posedge clk); #1 redirect = 1'b0;
      wait_acc(2, 30);
      chk("coinc_first", {acc_log[0].pc, acc_log[0].sz, acc_log[0].b0, acc_log[0].b1, acc_log[0].b2},
          {8'h80, 2'd2, 8'hB9, 8'h3C, 8'h00});
      chk("coinc_second_pc", acc_log[1].pc, 8'h82);

      // Instruction straddling 0xFF -> 0x00
      reset = 1'b1; load_filler();
      img[8'hFE] = 8'hD6; img[8'hFF] = 8'h12; img[8'h00] = 8'h34; img[8'h01] = 8'h0E;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; redirect = 1'b1; redirectAddr = 8'hFE; acc_log.delete();
      @(posedge clk); #1 redirect = 1'b0;
      wait_acc(2, 30);
      chk("wrap_instr", {acc_log[0].pc, acc_log[0].sz, acc_log[0].b0, acc_log[0].b1, acc_log[0].b2},
          {8'hFE, 2'd3, 8'hD6, 8'h12, 8'h34});
      chk("wrap_next", {acc_log[1].pc, acc_log[1].sz, acc_log[1].b0}, {8'h01, 2'd1, 8'h0E});

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
